// File: rtl/multi_flag_sync_rx.sv
// Multi-channel flag receiver: per-channel synchroniser, event pulse, sticky pending/overrun.
// Define MFS_EVENT_CNT_EN to build the per-channel saturating event counters behind cnt_flat.
module multi_flag_sync_rx #(
  parameter int             N           = 4,
  parameter int             SYNC_STAGES = 3,
  parameter logic [N-1:0]   EDGE_MODE   = {N{1'b1}},
  parameter int             CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       flag_in,
  input  logic [N-1:0]       ack,
  input  logic [N-1:0]       overrun_clr,
  output logic               ready,
  output logic [N-1:0]       pulse_out,
  output logic [N-1:0]       pending,
  output logic [N-1:0]       overrun,
  input  logic [N-1:0]       cnt_clr,
  output logic [N*CNT_W-1:0] cnt_flat
);

  localparam int PW = $clog2(SYNC_STAGES + 1);

  typedef enum logic {PRIME, RUN} state_t;

  state_t                           state;
  logic [PW-1:0]                    primeCnt;
  logic [N-1:0][SYNC_STAGES-1:0]    syncChain;
  logic [N-1:0]                     syncTop;
  logic [N-1:0]                     syncPrev;
  logic [N-1:0]                     rawEvt;
  logic [N-1:0]                     evt;

  // Priming: let the chains fill with the post-reset input level before events count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PRIME;
      primeCnt <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        PRIME: begin
          if (primeCnt == PW'(SYNC_STAGES)) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            primeCnt <= primeCnt + PW'(1);
          end
        end
        default: ready <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncChain <= '0;
      syncPrev  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        syncChain[i] <= {syncChain[i][SYNC_STAGES-2:0], flag_in[i]};
      end
      syncPrev <= syncTop;
    end
  end

  always_comb begin
    syncTop = '0;
    for (int i = 0; i < N; i++) begin
      syncTop[i] = syncChain[i][SYNC_STAGES-1];
    end
  end

  // Toggle channels fire on any edge, level channels on the rising edge only.
  assign rawEvt = (EDGE_MODE & (syncTop ^ syncPrev)) | (~EDGE_MODE & syncTop & ~syncPrev);
  assign evt    = rawEvt & {N{state == RUN}};

  // An event alongside ack keeps pending set and counts as consumed, so no overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_out <= '0;
      pending   <= '0;
      overrun   <= '0;
    end else begin
      pulse_out <= evt;
      pending   <= evt | (pending & ~ack);
      overrun   <= (evt & pending & ~ack) | (overrun & ~overrun_clr);
    end
  end

`ifdef MFS_EVENT_CNT_EN
  logic [N-1:0][CNT_W-1:0] evtCnt;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evtCnt <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cnt_clr[i]) begin
          evtCnt[i] <= evt[i] ? CNT_W'(1) : '0;
        end else if (evt[i]) begin
          evtCnt[i] <= satInc(evtCnt[i]);
        end
      end
    end
  end

  assign cnt_flat = evtCnt;
`else
  logic unusedCntClr;

  assign unusedCntClr = ^cnt_clr;
  assign cnt_flat     = '0;
`endif

endmodule

// File: tb/tb_multi_flag_sync_rx.sv
// Bench for multi_flag_sync_rx: directed steps then randomized traffic against a cycle-indexed model.
module tb_multi_flag_sync_rx;

  localparam int         N  = 4;
  localparam int         S  = 3;
  localparam logic [3:0] EM = 4'b1101;
  localparam int         CW = 2;
  localparam int         HL = 8192;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    flag_in = '0;
  logic [N-1:0]    ack = '0;
  logic [N-1:0]    overrun_clr = '0;
  logic [N-1:0]    cnt_clr = '0;
  logic            ready;
  logic [N-1:0]    pulse_out;
  logic [N-1:0]    pending;
  logic [N-1:0]    overrun;
  logic [N*CW-1:0] cnt_flat;

  multi_flag_sync_rx #(.N(N), .SYNC_STAGES(S), .EDGE_MODE(EM), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flag_in(flag_in), .ack(ack), .overrun_clr(overrun_clr),
    .ready(ready), .pulse_out(pulse_out), .pending(pending), .overrun(overrun),
    .cnt_clr(cnt_clr), .cnt_flat(cnt_flat)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  // Model: input value sampled at each edge since reset release, plus sticky flags.
  logic [N-1:0] hist [HL];
  int           edgeNo;
  logic         mReady;
  logic [N-1:0] mPulse, mPend, mOvr;
  int           mCnt [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*CW-1:0] packCnt();
    logic [N*CW-1:0] v = '0;
`ifdef MFS_EVENT_CNT_EN
    for (int i = 0; i < N; i++) v[i*CW +: CW] = CW'(mCnt[i]);
`endif
    return v;
  endfunction

  task automatic checkAll(input string tag);
    chk({tag, ".ready"},   32'(ready),     32'(mReady));
    chk({tag, ".pulse"},   32'(pulse_out), 32'(mPulse));
    chk({tag, ".pending"}, 32'(pending),   32'(mPend));
    chk({tag, ".overrun"}, 32'(overrun),   32'(mOvr));
    chk({tag, ".cnt"},     32'(cnt_flat),  32'(packCnt()));
  endtask

  task automatic modelClear();
    edgeNo = 0;
    mReady = 1'b0;
    mPulse = '0;
    mPend  = '0;
    mOvr   = '0;
    for (int i = 0; i < N; i++) mCnt[i] = 0;
  endtask

  // One clock edge: advance the model from the sampled inputs, then compare just after.
  task automatic tick(input string tag);
    logic [N-1:0] cur, old, ev;
    @(posedge clk);
    if (rst_n) begin
      edgeNo++;
      hist[edgeNo % HL] = flag_in;
      mReady = (edgeNo >= S + 1);
      ev = '0;
      if (edgeNo >= S + 2) begin
        cur = hist[(edgeNo - S) % HL];
        old = hist[(edgeNo - S - 1) % HL];
        for (int i = 0; i < N; i++)
          ev[i] = EM[i] ? (cur[i] != old[i]) : (cur[i] && !old[i]);
      end
      for (int i = 0; i < N; i++) begin
        if (ev[i] && mPend[i] && !ack[i]) mOvr[i] = 1'b1;
        else if (overrun_clr[i])          mOvr[i] = 1'b0;
        if (ev[i])       mPend[i] = 1'b1;
        else if (ack[i]) mPend[i] = 1'b0;
        if (cnt_clr[i])                 mCnt[i] = ev[i] ? 1 : 0;
        else if (ev[i] && mCnt[i] < 3)  mCnt[i]++;
      end
      mPulse = ev;
    end
    #1;
    checkAll(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int k = 0; k < n; k++) tick(tag);
  endtask

  task automatic assertReset(input string tag);
    rst_n = 1'b0;
    #1;
    modelClear();
    checkAll(tag);
    ticks(2, tag);
    rst_n = 1'b1;
  endtask

  int pAt, pCnt;
  int holdLeft [N];

  initial begin
    modelClear();

    // Reset with all lines high: priming must absorb the level without events.
    flag_in = 4'b1111;
    assertReset("rst");
    ticks(3, "prime");
    chk("ready_after3", 32'(ready), 32'd0);
    tick("prime4");
    chk("ready_after4", 32'(ready), 32'd1);
    ticks(6, "idle");
    chk("no_pend_after_prime", 32'(pending), 32'd0);

    // Toggle ch0: pulse appears after the 4th edge counting the sampling edge.
    flag_in[0] = ~flag_in[0];
    pAt = -1;
    pCnt = 0;
    for (int t = 1; t <= 8; t++) begin
      tick("tog0");
      if (pulse_out[0]) begin
        pCnt++;
        if (pAt < 0) pAt = t;
      end
    end
    chk("tog0_latency", 32'(pAt), 32'd4);
    chk("tog0_width", 32'(pCnt), 32'd1);
    chk("tog0_pending", 32'(pending), 32'b0001);
    ack[0] = 1'b1;
    tick("ack0");
    ack[0] = 1'b0;
    chk("ack0_clears", 32'(pending[0]), 32'd0);

    // Level ch1: fall then rise then fall, one event only.
    pCnt = 0;
    for (int ph = 0; ph < 3; ph++) begin
      flag_in[1] = (ph == 1);
      for (int t = 0; t < 10; t++) begin
        tick("lvl1");
        if (pulse_out[1]) pCnt++;
      end
    end
    chk("lvl1_pulses", 32'(pCnt), 32'd1);
    chk("lvl1_pending", 32'(pending[1]), 32'd1);

    // ch2 overrun, ack coinciding with a third event, then overrun clear.
    for (int e = 0; e < 2; e++) begin
      flag_in[2] = ~flag_in[2];
      ticks(5, "ovr2");
    end
    chk("ovr2_set", 32'(overrun[2]), 32'd1);
    chk("ovr2_pend", 32'(pending[2]), 32'd1);
    flag_in[2] = ~flag_in[2];
    ticks(3, "ev3");
    ack[2] = 1'b1;
    tick("ev3_ack");
    ack[2] = 1'b0;
    chk("ev3_pulse", 32'(pulse_out[2]), 32'd1);
    chk("ev3_pend_kept", 32'(pending[2]), 32'd1);
    ticks(2, "ev3_after");
    overrun_clr[2] = 1'b1;
    tick("ovrclr2");
    overrun_clr[2] = 1'b0;
    chk("ovr2_cleared", 32'(overrun[2]), 32'd0);
    ack = 4'b1111;
    tick("ackall");
    ack = '0;

    // All channels at once, then a reset while a second wave is in flight.
    flag_in = flag_in ^ 4'b1111;
    ticks(4, "all4");
    chk("all4_pulse", 32'(pulse_out), 32'b1111);
    ticks(3, "all4_tail");
    flag_in = flag_in ^ 4'b1111;
    ticks(2, "inflight");
    assertReset("midrst");
    pCnt = 0;
    for (int t = 0; t < 12; t++) begin
      tick("post_rst");
      if (pulse_out != '0) pCnt++;
    end
    chk("post_rst_no_pulse", 32'(pCnt), 32'd0);

    // Five events on ch3 saturate a 2-bit counter; clear with an event loads 1.
    for (int e = 0; e < 5; e++) begin
      flag_in[3] = ~flag_in[3];
      ticks(5, "cnt3");
    end
`ifdef MFS_EVENT_CNT_EN
    chk("cnt3_sat", 32'(cnt_flat[7:6]), 32'd3);
`else
    chk("cnt_off", 32'(cnt_flat), 32'd0);
`endif
    flag_in[3] = ~flag_in[3];
    ticks(3, "cnt3_pre");
    cnt_clr[3] = 1'b1;
    tick("cnt3_clr_ev");
    cnt_clr[3] = 1'b0;
`ifdef MFS_EVENT_CNT_EN
    chk("cnt3_clr_ev", 32'(cnt_flat[7:6]), 32'd1);
`else
    chk("cnt_off_clr", 32'(cnt_flat), 32'd0);
`endif

    // Randomized traffic with sparse acks/clears and one reset in the middle.
    for (int i = 0; i < N; i++) holdLeft[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (holdLeft[i] > 0) begin
          holdLeft[i]--;
        end else if ($urandom_range(0, 3) == 0) begin
          flag_in[i] = ~flag_in[i];
          holdLeft[i] = 4 + $urandom_range(0, 6);
        end
        ack[i]         = ($urandom_range(0, 5) == 0);
        overrun_clr[i] = ($urandom_range(0, 7) == 0);
        cnt_clr[i]     = ($urandom_range(0, 15) == 0);
      end
      if (c == 750) assertReset("rnd_rst");
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
